weight_loader: RTL and testbench
================================

Name: weight_loader

Overview:
- DMA-style writer that fills the weight buffer's DRAM-side write port.
- Accepts a load command (base line address, line count) and consumes a 64-bit DRAM read-data stream with valid/ready.
- Packs every 4 beats into one 256-bit line and issues one single-cycle write per line, on consecutive buffer addresses.
- Sits between the DRAM read channel and the weight buffer; drives that buffer's request, write-enable, address and write-data inputs.

Parameters:
- ADDR_WIDTH, 8, buffer line address width; addresses wrap modulo 2^ADDR_WIDTH.
- LINE_WIDTH, 256, buffer line width in bits.
- BEAT_WIDTH, 64, DRAM stream beat width; BEATS = LINE_WIDTH/BEAT_WIDTH = 4, must divide exactly.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  load command valid.
- cmd_ready  output  1  loader can accept a command; high only in IDLE.
- cmd_base_addr  input  ADDR_WIDTH  first buffer line to write.
- cmd_num_lines  input  ADDR_WIDTH+1  lines to load, 0..2^ADDR_WIDTH.
- dram_rvalid  input  1  stream beat valid.
- dram_rready  output  1  loader accepts beat.
- dram_rdata  input  BEAT_WIDTH  stream beat.
- out_dram_req  output  1  buffer write request, one-cycle pulse per line.
- out_dram_we  output  1  write enable; always equal to out_dram_req.
- out_dram_addr  output  ADDR_WIDTH  buffer line address.
- out_dram_wdata  output  LINE_WIDTH  packed line.
- busy  output  1  high in STREAM and DONE.
- done  output  1  one-cycle pulse at command completion.

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready=1. The beat counter, line counter, address and pack register are cleared. Reset mid-command discards any partial line, and no write issues afterwards.
- All outputs are registered, except cmd_ready and dram_rready, which decode directly from state.
- States: IDLE, STREAM, DONE.
- IDLE: cmd_ready=1, dram_rready=0.
  - cmd_valid&cmd_ready with cmd_num_lines!=0: latch base address and count, clear beat counter, go to STREAM.
  - cmd_num_lines==0: go to DONE, no write.
- STREAM: dram_rready=1, cmd_ready=0.
  - Each accepted beat (rvalid&rready) is stored into pack slot k = beat counter: bits [64k+63:64k]. The first beat lands in the LSBs.
  - Beat counter wraps 3 -> 0.
  - Gaps (rvalid=0) stall packing with no effect on state.
- Write issue: the 4th beat of a line is accepted in cycle t. In cycle t+1:
  - out_dram_req=out_dram_we=1;
  - out_dram_addr = current line address;
  - out_dram_wdata = all 4 beats of that line.
  - In t+1 the line address increments modulo 2^ADDR_WIDTH and the remaining count decrements.
  - Writes are never back-to-back closer than 4 cycles. The buffer has no backpressure.
- Last line: on the cycle its 4th beat is accepted, dram_rready drops in the next cycle and state goes to DONE.
- DONE (exactly one cycle): done=1.
  - The last line's write pulse occurs in this same cycle.
  - For a zero-length command, done=1 with no write.
  - Next cycle: IDLE, cmd_ready=1.
- out_dram_addr/out_dram_wdata hold their last values when req=0; the value is don't-care for verification.
- Beats offered while not in STREAM are not accepted (rready=0); the stream source must hold them.
- A command presented while busy is ignored, since cmd_ready=0; it must be held by the source.
- Total latency: from command acceptance to done is ≥ 4·N+1 cycles for N lines at full stream rate.

Test Plan:
- Base 0x10, N=2; beats 0x..01..0x..08 back-to-back.
  - Expected: write at 0x10 with wdata {b4,b3,b2,b1}, write at 0x11 with {b8,b7,b6,b5}.
  - Writes 4 cycles apart; done coincides with 2nd write; cmd_ready returns next cycle.
- Base 0xFE, N=4.
  - Expected: addresses 0xFE, 0xFF, 0x00, 0x01 (wrap); exactly 4 write pulses.
- N=1 with rvalid toggling 1,0,0,1,1,0,1.
  - Expected: single write one cycle after the 4th accepted beat; packing order preserved despite gaps.
- N=0.
  - Expected: done pulse in the cycle after acceptance; no out_dram_req; dram_rready stays 0.
- N=256, base 0x00.
  - Expected: 256 writes covering 0x00..0xFF once each; done after the last.
  - A second cmd_valid held during the run is accepted only after return to IDLE.
- Assert rst_n low after 2 beats of line 1 of N=3.
  - Expected: outputs cleared asynchronously; no write for the partial line.
  - A new command after reset packs from slot 0.

Source files
------------

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - packs DRAM read beats into weight-buffer lines and issues one write per line
module weight_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [ADDR_WIDTH:0]   cmd_num_lines,
    input  logic                  dram_rvalid,
    output logic                  dram_rready,
    input  logic [BEAT_WIDTH-1:0] dram_rdata,
    output logic                  out_dram_req,
    output logic                  out_dram_we,
    output logic [ADDR_WIDTH-1:0] out_dram_addr,
    output logic [LINE_WIDTH-1:0] out_dram_wdata,
    output logic                  busy,
    output logic                  done
);
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      beat_cnt;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [ADDR_WIDTH:0]   lines_left;
    logic [LINE_WIDTH-1:0] pack;
    logic [LINE_WIDTH-1:0] next_line;
    logic                  beat_fire;
    logic                  line_full;

    assign cmd_ready   = (state == IDLE);
    assign dram_rready = (state == STREAM);
    assign beat_fire   = dram_rvalid && dram_rready;
    assign line_full   = (beat_cnt == CNT_W'(BEATS - 1));

    // Pack register with the incoming beat merged in, so the 4th beat goes straight to the write data.
    always_comb begin
        next_line = pack;
        next_line[int'(beat_cnt) * BEAT_WIDTH +: BEAT_WIDTH] = dram_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            line_addr      <= '0;
            lines_left     <= '0;
            pack           <= '0;
            out_dram_req   <= 1'b0;
            out_dram_we    <= 1'b0;
            out_dram_addr  <= '0;
            out_dram_wdata <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            out_dram_req <= 1'b0;
            out_dram_we  <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        line_addr  <= cmd_base_addr;
                        lines_left <= cmd_num_lines;
                        beat_cnt   <= '0;
                        busy       <= 1'b1;
                        if (cmd_num_lines == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (beat_fire) begin
                        pack <= next_line;
                        if (line_full) begin
                            beat_cnt       <= '0;
                            out_dram_req   <= 1'b1;
                            out_dram_we    <= 1'b1;
                            out_dram_addr  <= line_addr;
                            out_dram_wdata <= next_line;
                            line_addr      <= line_addr + ADDR_WIDTH'(1);
                            lines_left     <= lines_left - (ADDR_WIDTH + 1)'(1);
                            if (lines_left == (ADDR_WIDTH + 1)'(1)) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - randomized self-checking bench for weight_loader
module tb_weight_loader;
    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_base_addr;
    logic [8:0]   cmd_num_lines;
    logic         dram_rvalid;
    logic         dram_rready;
    logic [63:0]  dram_rdata;
    logic         out_dram_req;
    logic         out_dram_we;
    logic [7:0]   out_dram_addr;
    logic [255:0] out_dram_wdata;
    logic         busy;
    logic         done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0]   wr_addr[$];
    logic [255:0] wr_data[$];
    int           wr_cyc[$];
    int           done_q[$];
    int           acc_q[$];
    bit           rdy_at[int];
    bit           rrdy_seen;
    int           busy_n;
    logic [63:0]  beats[$];
    int           beat_cyc[$];
    int           acc_cyc;

    weight_loader dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_addr(cmd_base_addr), .cmd_num_lines(cmd_num_lines),
        .dram_rvalid(dram_rvalid), .dram_rready(dram_rready), .dram_rdata(dram_rdata),
        .out_dram_req(out_dram_req), .out_dram_we(out_dram_we),
        .out_dram_addr(out_dram_addr), .out_dram_wdata(out_dram_wdata),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observer: records every write, done pulse, command handshake and ready level per cycle.
    always @(negedge clk) begin
        if (out_dram_req) begin
            wr_addr.push_back(out_dram_addr);
            wr_data.push_back(out_dram_wdata);
            wr_cyc.push_back(cyc);
        end
        if (out_dram_req || out_dram_we) begin
            vectors++;
            if (out_dram_we !== out_dram_req) begin
                miscompares++;
                $display("FAIL we_eq_req cycle %0d: we=%b req=%b", cyc, out_dram_we, out_dram_req);
            end
        end
        if (done) done_q.push_back(cyc);
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        rdy_at[cyc] = cmd_ready;
        if (dram_rready) rrdy_seen = 1'b1;
        if (busy) busy_n++;
    end

    // gap_mode: 0 = full rate, 1 = fixed 1,0,0,1,1,0,1 pattern, 2 = random valid
    task automatic run_cmd(input logic [7:0] base, input int n, input int gap_mode, input bit hold);
        int got;
        int guard;
        bit v;
        bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        done_q.delete(); acc_q.delete(); rdy_at.delete();
        beats.delete(); beat_cyc.delete();
        rrdy_seen = 1'b0;
        busy_n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_base_addr = base;
        cmd_num_lines = 9'(n);
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        acc_cyc = cyc;
        @(posedge clk); #1;
        if (hold) begin
            cmd_base_addr = 8'h55;
            cmd_num_lines = 9'd0;
        end else begin
            cmd_valid = 1'b0;
        end
        got = 0;
        guard = 0;
        while (got < 4 * n && guard < 20000) begin
            v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? pat[guard % 7] : 1'($urandom_range(0, 1));
            dram_rvalid = v;
            dram_rdata = {$urandom, $urandom};
            if (v && dram_rready) begin
                beats.push_back(dram_rdata);
                beat_cyc.push_back(cyc);
                got++;
            end
            @(posedge clk); #1;
            guard++;
        end
        dram_rvalid = (n == 0);
        repeat (2) begin @(posedge clk); #1; end
        cmd_valid = 1'b0;
        dram_rvalid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_base_addr = '0; cmd_num_lines = '0;
        dram_rvalid = 1'b0; dram_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({cmd_ready, dram_rready, out_dram_req, out_dram_we, busy, done} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {cmd_ready, dram_rready, out_dram_req, out_dram_we, busy, done});
        end
        vectors++;
        if (out_dram_addr !== 8'h00 || out_dram_wdata !== 256'h0) begin
            miscompares++;
            $display("FAIL reset_data: addr %h wdata %h want 0", out_dram_addr, out_dram_wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load(input string name, input logic [7:0] base, input int n, input int gap_mode);
        logic [255:0] exp_data;
        logic [7:0]   exp_addr;
        int           exp_done;
        run_cmd(base, n, gap_mode, 1'b0);
        exp_done = beat_cyc[4 * n - 1] + 1;
        vectors++;
        if (wr_addr.size() != n) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d want %0d", name, wr_addr.size(), n);
        end
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            exp_addr = base + 8'(i);
            exp_data = {beats[4 * i + 3], beats[4 * i + 2], beats[4 * i + 1], beats[4 * i]};
            vectors += 3;
            if (wr_addr[i] !== exp_addr) begin
                miscompares++;
                $display("FAIL %s addr[%0d]: got %h want %h", name, i, wr_addr[i], exp_addr);
            end
            if (wr_data[i] !== exp_data) begin
                miscompares++;
                $display("FAIL %s wdata[%0d]: got %h want %h", name, i, wr_data[i], exp_data);
            end
            if (wr_cyc[i] != beat_cyc[4 * i + 3] + 1) begin
                miscompares++;
                $display("FAIL %s wcycle[%0d]: got %0d want %0d", name, i, wr_cyc[i], beat_cyc[4 * i + 3] + 1);
            end
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] != exp_done) begin
            miscompares++;
            $display("FAIL %s done: got %0d pulses first at %0d want 1 at %0d",
                     name, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, exp_done);
        end
        vectors++;
        if (busy_n != exp_done - acc_cyc) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, exp_done - acc_cyc);
        end
        vectors++;
        if (rdy_at[exp_done] !== 1'b0 || rdy_at[exp_done + 1] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s cmd_ready_after_done: got %b%b want 01", name, rdy_at[exp_done], rdy_at[exp_done + 1]);
        end
    endtask

    task automatic test_zero_len();
        run_cmd(8'h33, 0, 0, 1'b0);
        vectors++;
        if (wr_addr.size() != 0) begin
            miscompares++;
            $display("FAIL zero_len writes: got %0d want 0", wr_addr.size());
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] != acc_cyc + 1) begin
            miscompares++;
            $display("FAIL zero_len done: got %0d pulses want 1 at %0d", done_q.size(), acc_cyc + 1);
        end
        vectors++;
        if (rrdy_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len rready: got %b want 0", rrdy_seen);
        end
    endtask

    task automatic test_full_held();
        int d;
        run_cmd(8'h00, 256, 0, 1'b1);
        d = beat_cyc[1023] + 1;
        vectors++;
        if (wr_addr.size() != 256) begin
            miscompares++;
            $display("FAIL full writes: got %0d want 256", wr_addr.size());
        end
        for (int i = 0; i < 256 && i < wr_addr.size(); i++) begin
            vectors++;
            if (wr_addr[i] !== 8'(i) ||
                wr_data[i] !== {beats[4 * i + 3], beats[4 * i + 2], beats[4 * i + 1], beats[4 * i]}) begin
                miscompares++;
                $display("FAIL full line[%0d]: addr %h want %h", i, wr_addr[i], 8'(i));
            end
        end
        vectors++;
        if (done_q.size() != 2 || done_q[0] != d || done_q[1] != d + 2) begin
            miscompares++;
            $display("FAIL full done: got %0d pulses first at %0d want 2 at %0d,%0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, d, d + 2);
        end
        vectors++;
        if (acc_q.size() != 2 || acc_q[1] != d + 1) begin
            miscompares++;
            $display("FAIL held_cmd accept: got %0d accepts second at %0d want 2 with second at %0d",
                     acc_q.size(), (acc_q.size() > 1) ? acc_q[1] : -1, d + 1);
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] exp_data;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        beats.delete(); beat_cyc.delete();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_base_addr = 8'h40; cmd_num_lines = 9'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dram_rvalid = 1'b1;
            dram_rdata = {$urandom, $urandom};
            if (dram_rready) beats.push_back(dram_rdata);
            @(posedge clk); #1;
        end
        dram_rvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({cmd_ready, dram_rready, out_dram_req, busy, done} !== 5'b10000 || out_dram_addr !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid clear: got %b addr %h want 10000 addr 00",
                     {cmd_ready, dram_rready, out_dram_req, busy, done}, out_dram_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        exp_data = (beats.size() >= 4) ? {beats[3], beats[2], beats[1], beats[0]} : '0;
        vectors++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 8'h40 || wr_data[0] !== exp_data) begin
            miscompares++;
            $display("FAIL reset_mid writes: got %0d writes want exactly 1 at 40", wr_addr.size());
        end
        test_load("after_reset", 8'h80, 1, 0);
    endtask

    initial begin
        test_reset();
        test_load("basic", 8'h10, 2, 0);
        test_load("wrap", 8'hFE, 4, 0);
        test_load("gaps", 8'h20, 1, 1);
        test_zero_len();
        test_full_held();
        test_reset_mid();
        for (int k = 0; k < 4; k++)
            test_load("random", 8'($urandom_range(0, 255)), $urandom_range(1, 6), 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
